// File: rtl/dm_access_stage.sv
// Data-memory access stage: multi-cycle word memory, upstream stall and a
// registered write-back bundle for the DM/WB register.
module dm_access_stage #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  rd_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  output logic        stall_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_rd_out,
  output logic        wb_reg_write_out,
  output logic        wb_valid_out,
  output logic        misalign_err_out
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [4:0]        lat_rd;
  logic              lat_mtr;
  logic              lat_rw;
  logic              lat_store;

  logic              req;
  logic              aligned;
  logic [ADDR_W-1:0] lat_idx;
  logic              mem_we;
  logic [31:0]       rd_word;

  assign req       = mem_read_in | mem_write_in;
  assign aligned   = (alu_result_in[1:0] == 2'b00);
  assign stall_out = ((state == IDLE) && req && aligned) || (state == BUSY);
  assign lat_idx   = lat_addr[ADDR_W+1:2];
  // Store commits only on the last BUSY cycle; reset forces IDLE so an
  // abandoned store never reaches the array.
  assign mem_we    = (state == BUSY) && (cnt == '0) && lat_store;
  assign rd_word   = mem[lat_idx];

  // Memory array write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (mem_we) mem[lat_idx] <= lat_wdata;
  end

  // Access FSM with registered write-back bundle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      lat_addr         <= '0;
      lat_wdata        <= '0;
      lat_rd           <= '0;
      lat_mtr          <= 1'b0;
      lat_rw           <= 1'b0;
      lat_store        <= 1'b0;
      wb_data_out      <= '0;
      wb_rd_out        <= '0;
      wb_reg_write_out <= 1'b0;
      wb_valid_out     <= 1'b0;
      misalign_err_out <= 1'b0;
    end else begin
      misalign_err_out <= 1'b0;
      case (state)
        IDLE: begin
          if (!req) begin
            wb_data_out      <= alu_result_in;
            wb_rd_out        <= rd_in;
            wb_reg_write_out <= reg_write_in;
            wb_valid_out     <= 1'b1;
          end else if (!aligned) begin
            wb_data_out      <= alu_result_in;
            wb_rd_out        <= rd_in;
            wb_reg_write_out <= 1'b0;
            wb_valid_out     <= 1'b1;
            misalign_err_out <= 1'b1;
          end else begin
            lat_addr     <= alu_result_in;
            lat_wdata    <= write_data_in;
            lat_rd       <= rd_in;
            lat_mtr      <= mem_to_reg_in;
            lat_rw       <= reg_write_in;
            lat_store    <= mem_write_in;
            cnt          <= CNT_W'(LATENCY - 1);
            wb_valid_out <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            wb_data_out      <= (!lat_store && lat_mtr) ? rd_word : lat_addr;
            wb_rd_out        <= lat_rd;
            wb_reg_write_out <= lat_rw;
            wb_valid_out     <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          wb_valid_out     <= 1'b0;
          wb_reg_write_out <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_stage.sv
// Bench for dm_access_stage: table of instructions with hand-derived
// write-back results, checked through an in-order scoreboard.
module tb_dm_access_stage;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] write_data_in = '0;
  logic [4:0]  rd_in = '0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        mem_to_reg_in = 1'b0;
  logic        reg_write_in = 1'b0;
  logic        stall_out;
  logic [31:0] wb_data_out;
  logic [4:0]  wb_rd_out;
  logic        wb_reg_write_out;
  logic        wb_valid_out;
  logic        misalign_err_out;

  always #5 clk = ~clk;

  dm_access_stage #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk              (clk),
    .reset            (reset),
    .alu_result_in    (alu_result_in),
    .write_data_in    (write_data_in),
    .rd_in            (rd_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .mem_to_reg_in    (mem_to_reg_in),
    .reg_write_in     (reg_write_in),
    .stall_out        (stall_out),
    .wb_data_out      (wb_data_out),
    .wb_rd_out        (wb_rd_out),
    .wb_reg_write_out (wb_reg_write_out),
    .wb_valid_out     (wb_valid_out),
    .misalign_err_out (misalign_err_out)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        rw;
    int          exp_stall;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;

  localparam int NV = 19;
  vec_t tbl [NV];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  function automatic vec_t mk(logic [31:0] alu, logic [31:0] wdata, logic [4:0] rd,
                              logic mr, logic mw, logic mtr, logic rw, int st,
                              logic [31:0] ed, logic erw, logic emis);
    vec_t v;
    v.alu = alu; v.wdata = wdata; v.rd = rd; v.mr = mr; v.mw = mw;
    v.mtr = mtr; v.rw = rw; v.exp_stall = st; v.exp_data = ed;
    v.exp_rw = erw; v.exp_mis = emis;
    return v;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    alu_result_in = v.alu;
    write_data_in = v.wdata;
    rd_in         = v.rd;
    mem_read_in   = v.mr;
    mem_write_in  = v.mw;
    mem_to_reg_in = v.mtr;
    reg_write_in  = v.rw;
  endtask

  // Apply one instruction, hold it while stalled, and queue its write-back.
  task automatic issue(vec_t v, bit rel);
    int   st;
    exp_t e;
    @(negedge clk);
    if (rel) reset = 1'b1;
    drive(v);
    e.data = v.exp_data; e.rd = v.rd; e.rw = v.exp_rw; e.mis = v.exp_mis;
    sb.push_back(e);
    st = 0;
    #1;
    while (stall_out && st < 50) begin
      st++;
      @(negedge clk);
      #1;
    end
    check32("stall_cycles", 32'(st), 32'(v.exp_stall));
  endtask

  // Monitor: every valid write-back cycle must match the oldest queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done && reset) begin
        if (!wb_valid_out) check32("misalign_without_valid", 32'(misalign_err_out), 32'd0);
        if (wb_valid_out) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb: got data %h rd %0d, expected none", wb_data_out, wb_rd_out);
          end else begin
            e = sb.pop_front();
            check32("wb_data", wb_data_out, e.data);
            check32("wb_rd", 32'(wb_rd_out), 32'(e.rd));
            check32("wb_reg_write", 32'(wb_reg_write_out), 32'(e.rw));
            check32("misalign_err", 32'(misalign_err_out), 32'(e.mis));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t z;
    z = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0);

    tbl[0]  = mk(32'h42,       32'h0,        5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h42,       1'b1, 1'b0);
    tbl[1]  = mk(32'h10,       32'hDEADBEEF, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h10,       1'b0, 1'b0);
    tbl[2]  = mk(32'h10,       32'h0,        5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[3]  = mk(32'h13,       32'h0,        5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h13,       1'b0, 1'b1);
    tbl[4]  = mk(32'h10,       32'h0,        5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[5]  = mk(32'h400,      32'h1234,     5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h400,      1'b0, 1'b0);
    tbl[6]  = mk(32'h0,        32'h0,        5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h1234,     1'b1, 1'b0);
    tbl[7]  = mk(32'h20,       32'hA5A5,     5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h20,       1'b0, 1'b0);
    tbl[8]  = mk(32'h24,       32'h5A5A,     5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h24,       1'b0, 1'b0);
    tbl[9]  = mk(32'h20,       32'h0,        5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hA5A5,     1'b1, 1'b0);
    tbl[10] = mk(32'h24,       32'h0,        5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h5A5A,     1'b1, 1'b0);
    tbl[11] = mk(32'h24,       32'h0,        5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 3, 32'h24,       1'b1, 1'b0);
    tbl[12] = mk(32'h28,       32'h77,       5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 3, 32'h28,       1'b1, 1'b0);
    tbl[13] = mk(32'h28,       32'h0,        5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h77,       1'b1, 1'b0);
    tbl[14] = mk(32'h2A,       32'hFF,       5'd2,  1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h2A,       1'b0, 1'b1);
    tbl[15] = mk(32'h28,       32'h0,        5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h77,       1'b1, 1'b0);
    tbl[16] = mk(32'hCAFEF00D, 32'h0,        5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
    tbl[17] = mk(32'h0C,       32'h11111111, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h0C,       1'b0, 1'b0);
    tbl[18] = mk(32'h40C,      32'h0,        5'd15, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h11111111, 1'b1, 1'b0);

    // Reset state.
    #12;
    check32("rst_wb_data", wb_data_out, 32'h0);
    check32("rst_wb_rd", 32'(wb_rd_out), 32'd0);
    check32("rst_wb_reg_write", 32'(wb_reg_write_out), 32'd0);
    check32("rst_wb_valid", 32'(wb_valid_out), 32'd0);
    check32("rst_misalign", 32'(misalign_err_out), 32'd0);
    check32("rst_stall", 32'(stall_out), 32'd0);

    for (int i = 0; i < NV; i++) issue(tbl[i], i == 0);

    // Reset mid-BUSY abandons a store to word 3.
    @(negedge clk);
    drive(mk(32'h0C, 32'h22222222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0));
    #1;
    check32("abort_stall_idle", 32'(stall_out), 32'd1);
    @(negedge clk);
    #1;
    check32("abort_stall_busy", 32'(stall_out), 32'd1);
    check32("abort_valid_busy", 32'(wb_valid_out), 32'd0);
    reset = 1'b0;
    drive(z);
    #1;
    check32("async_rst_wb_data", wb_data_out, 32'h0);
    check32("async_rst_wb_rd", 32'(wb_rd_out), 32'd0);
    check32("async_rst_reg_write", 32'(wb_reg_write_out), 32'd0);
    check32("async_rst_valid", 32'(wb_valid_out), 32'd0);
    check32("async_rst_misalign", 32'(misalign_err_out), 32'd0);
    check32("async_rst_stall", 32'(stall_out), 32'd0);
    repeat (2) @(negedge clk);
    issue(mk(32'h0C, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'h11111111, 1'b1, 1'b0), 1'b1);

    // Trailing no-ops drain the pipeline.
    issue(z, 1'b0);
    issue(z, 1'b0);
    @(negedge clk);
    #2;
    done = 1'b1;
    check32("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
